// File: rtl/sinepwm_multi_if.sv
// Control and output bundle of the multi-channel sine PWM generator.
// The master side drives run/stop, frequency and amplitude; the slave side
// (the generator) returns the registered enable and the PWM pins.
interface sinepwm_multi_if #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
);
  logic                 enable;
  logic signed [31:0]   freq;
  logic [PWM_BITS-1:0]  amp;
  logic                 en;
  logic [CHANNELS-1:0]  pwm_out;

  modport master (output enable, freq, amp, input en, pwm_out);
  modport slave  (input enable, freq, amp, output en, pwm_out);
endinterface

// File: rtl/sinepwm_multi.sv
// Multi-channel sine PWM generator. A 32-bit phase accumulator advances by a
// signed frequency word once per carrier period and addresses a full-wave sine
// ROM at CHANNELS equally spaced phase offsets. Each channel's duty is scaled
// by a run-time amplitude and loaded only on the last tick of the carrier
// period, so every PWM period is produced from one consistent duty value.
module sinepwm_multi #(
  parameter int          CHANNELS    = 3,
  parameter int          PWM_BITS    = 8,
  parameter int          TABLE_BITS  = 6,
  parameter int          DIVIDER     = 1000,
  parameter logic [31:0] START_PHASE = 32'h0
) (
  input logic           clk,
  input logic           rst,
  sinepwm_multi_if.slave bus
);

  localparam int PERIOD   = (1 << PWM_BITS) - 1;
  localparam int DEPTH    = 1 << TABLE_BITS;
  localparam int PRESC_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int AMP_MAX  = (1 << (PWM_BITS - 1)) - 1;
  localparam int PROD_W   = 2 * PWM_BITS + 1;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DIVIDER - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST   = PWM_BITS'(PERIOD - 1);
  localparam logic [PWM_BITS-1:0] MID        = PWM_BITS'(1 << (PWM_BITS - 1));

  // Rounded sine sample scaled to the signed half-range; evaluated only on
  // constant indices, so the table folds into a ROM.
  function automatic logic signed [PWM_BITS-1:0] sineEntry(input int i);
    real ang;
    real s;
    int  r;
    ang = 2.0 * 3.14159265358979323846 * real'(i) / real'(DEPTH);
    s   = $sin(ang) * real'(AMP_MAX);
    if (s >= 0.0) r = $rtoi(s + 0.5);
    else          r = -$rtoi(0.5 - s);
    return PWM_BITS'(r);
  endfunction

  // Phase offset of channel k: floor(k * 2^32 / CHANNELS).
  function automatic logic [31:0] chanOffset(input int k);
    return 32'((64'(k) << 32) / 64'(CHANNELS));
  endfunction

  logic signed [PWM_BITS-1:0] sineRom [DEPTH];

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q [CHANNELS];
  logic [PWM_BITS-1:0] duty_d [CHANNELS];
  logic [PWM_BITS-1:0] newDuty [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                en_q;

  logic tick;
  logic update;

  for (genvar i = 0; i < DEPTH; i++) begin : gRom
    assign sineRom[i] = sineEntry(i);
  end

  assign tick   = (presc_q == PRESC_LAST);
  assign update = tick && (cnt_q == CNT_LAST);

  // Candidate duty per channel from the current (pre-update) phase. The
  // product is floored by an arithmetic shift and re-centred on mid-scale.
  for (genvar k = 0; k < CHANNELS; k++) begin : gChan
    localparam logic [31:0] OFFSET = chanOffset(k);
    logic [TABLE_BITS-1:0] idx;
    logic signed [PROD_W-1:0] prod;
    assign idx  = TABLE_BITS'((phase_q + OFFSET) >> (32 - TABLE_BITS));
    assign prod = PROD_W'(sineRom[idx]) * PROD_W'($signed({1'b0, bus.amp}));
    assign newDuty[k] = MID + PWM_BITS'(prod >>> PWM_BITS);
  end

  // Next-state: prescaler, carrier, accumulator, duty latch and PWM compare.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    phase_d = phase_q;
    duty_d  = duty_q;
    if (!bus.enable) begin
      for (int k = 0; k < CHANNELS; k++) duty_d[k] = '0;
    end else if (update) begin
      phase_d = phase_q + bus.freq;
      duty_d  = newDuty;
    end
    pwm_d = '0;
    for (int k = 0; k < CHANNELS; k++) pwm_d[k] = en_q && (cnt_q < duty_q[k]);
  end

  // State registers; reset overrides everything, including a mid-period state.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      phase_q <= START_PHASE;
      duty_q  <= '{default: '0};
      pwm_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      en_q    <= bus.enable;
    end
  end

  assign bus.en      = en_q;
  assign bus.pwm_out = pwm_q;

endmodule

// File: tb/tb_sinepwm_multi.sv
// Self-checking bench for sinepwm_multi (DIVIDER=1, 8-bit PWM, 64-entry
// table, 3 channels). PWM high time is measured per carrier period and
// compared with a floating-point reference model of the phase accumulator.
module tb_sinepwm_multi;

  localparam int CH     = 3;
  localparam int PB     = 8;
  localparam int TBITS  = 6;
  localparam int PERIOD = (1 << PB) - 1;
  localparam real PI    = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sinepwm_multi_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();

  sinepwm_multi #(
    .CHANNELS(CH), .PWM_BITS(PB), .TABLE_BITS(TBITS),
    .DIVIDER(1), .START_PHASE(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] mPhase;
  int          mDuty [CH];
  int          hi    [CH];

  // Reference duty straight from the sine formula using real arithmetic.
  function automatic int refDuty(input logic [31:0] ph, input int k, input int a);
    longint off;
    logic [31:0] p;
    int idx;
    real s;
    int t;
    off = (longint'(k) << 32) / CH;
    p   = ph + 32'(off);
    idx = int'(p >> (32 - TBITS));
    s   = $sin(2.0 * PI * real'(idx) / real'(1 << TBITS)) * real'((1 << (PB - 1)) - 1);
    if (s >= 0.0) t = int'($floor(s + 0.5));
    else          t = -int'($floor(-s + 0.5));
    return (1 << (PB - 1)) + int'($floor(real'(t * a) / real'(1 << PB)));
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic e, input logic [31:0] f, input int a);
    bus.enable = e;
    bus.freq   = f;
    bus.amp    = PB'(a);
  endtask

  task automatic modelReset();
    mPhase = 32'h0;
    for (int k = 0; k < CH; k++) mDuty[k] = 0;
  endtask

  // One clock, sampled on the falling edge, accumulating PWM high time.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < CH; k++) hi[k] += int'(bus.pwm_out[k]);
  endtask

  task automatic runCycles(input int n);
    repeat (n) step();
  endtask

  task automatic beginWindow();
    for (int k = 0; k < CH; k++) hi[k] = 0;
  endtask

  // Close a carrier period: compare high times, then apply the update that
  // happened on its last tick to the model.
  task automatic endWindow(input string tag, input bit doCheck);
    if (doCheck)
      for (int k = 0; k < CH; k++)
        checkOutput($sformatf("%s_ch%0d", tag, k), hi[k], mDuty[k]);
    if (bus.enable) begin
      for (int k = 0; k < CH; k++) mDuty[k] = refDuty(mPhase, k, int'(bus.amp));
      mPhase = mPhase + bus.freq;
    end
  endtask

  task automatic fullWindow(input string tag);
    beginWindow();
    runCycles(PERIOD);
    endWindow(tag, 1'b1);
  endtask

  initial begin
    // Reset with the static-offset stimulus already applied
    applyStimulus(1'b1, 32'h0, 255);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_en", int'(bus.en), 0);
    checkOutput("reset_pwm", int'(bus.pwm_out), 0);
    modelReset();
    rst = 1'b0;

    // First period after reset: no duty loaded yet, registered enable rises
    beginWindow();
    runCycles(1);
    checkOutput("en_rise", int'(bus.en), 1);
    runCycles(PERIOD - 1);
    endWindow("idle", 1'b1);

    // Static offsets: 0/120/240 degrees
    fullWindow("static");
    checkOutput("static_c0", hi[0], 128);
    checkOutput("static_c1", hi[1], 239);
    checkOutput("static_c2", hi[2], 22);
    fullWindow("static2");

    // Forward rotation by one table step per period
    applyStimulus(1'b1, 32'h0400_0000, 255);
    for (int i = 0; i < 66; i++) begin
      fullWindow($sformatf("fwd%0d", i));
      if (i == 17) checkOutput("fwd_idx16", hi[0], 254);
      if (i == 49) checkOutput("fwd_idx48", hi[0], 1);
    end

    // Reset in mid-period (cnt=100) with duties loaded
    beginWindow();
    runCycles(100);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h0, 255);
    step();
    checkOutput("midrst_pwm", int'(bus.pwm_out), 0);
    checkOutput("midrst_en", int'(bus.en), 0);
    modelReset();
    rst = 1'b0;
    beginWindow();
    runCycles(1);
    checkOutput("midrst_en_rise", int'(bus.en), 1);
    runCycles(PERIOD - 1);
    endWindow("midrst_idle", 1'b1);
    fullWindow("midrst_static");
    checkOutput("midrst_c0", hi[0], 128);
    checkOutput("midrst_c1", hi[1], 239);
    checkOutput("midrst_c2", hi[2], 22);

    // Reverse rotation from phase 0
    applyStimulus(1'b1, 32'hFC00_0000, 255);
    for (int j = 0; j < 4; j++) begin
      fullWindow($sformatf("rev%0d", j));
      if (j == 2) checkOutput("rev_idx63", hi[0], 116);
    end

    // Zero amplitude centres every channel
    applyStimulus(1'b1, 32'h0400_0000, 0);
    for (int j = 0; j < 4; j++) fullWindow($sformatf("amp0_%0d", j));
    for (int k = 0; k < CH; k++) checkOutput($sformatf("amp0_c%0d", k), hi[k], 128);

    // Random frequency and amplitude, changed mid-period
    for (int j = 0; j < 20; j++) begin
      int split;
      split = int'($urandom_range(1, PERIOD - 1));
      beginWindow();
      runCycles(split);
      applyStimulus(1'b1, $urandom(), int'($urandom_range(0, 255)));
      runCycles(PERIOD - split);
      endWindow($sformatf("rnd%0d", j), 1'b1);
    end

    // Drop enable mid-period: duties clear at once, phase freezes
    beginWindow();
    runCycles(60);
    bus.enable = 1'b0;
    for (int k = 0; k < CH; k++) mDuty[k] = 0;
    step();
    checkOutput("dis_en", int'(bus.en), 0);
    step();
    checkOutput("dis_pwm", int'(bus.pwm_out), 0);
    runCycles(PERIOD - 62);
    endWindow("dis_partial", 1'b0);
    for (int j = 0; j < 10; j++) fullWindow($sformatf("off%0d", j));
    checkOutput("off_en", int'(bus.en), 0);

    // Re-enable mid-period: output returns at the next update, same phase
    beginWindow();
    runCycles(100);
    bus.enable = 1'b1;
    runCycles(PERIOD - 100);
    endWindow("reen_wait", 1'b1);
    for (int j = 0; j < 3; j++) fullWindow($sformatf("reen%0d", j));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sinepwm_multi.md
Name: sinepwm_multi

Overview:
- Multi-channel sine PWM generator; successor to the single-channel table-stepping sine PWM.
- A 32-bit phase accumulator (DDS) is driven by a signed frequency word. It feeds CHANNELS outputs, equally phase-shifted (CHANNELS=3 gives 120°).
- Amplitude is scalable at run time. Resolution and table depth are set by parameters.
- Duty updates are glitch-free, at carrier period boundaries only. Sits between the motor/stepper interface registers and the output pins.

Parameters:
- CHANNELS, 3, number of phase-shifted outputs (1..8).
- PWM_BITS, 8, carrier resolution; carrier period PERIOD = 2^PWM_BITS-1 ticks.
- TABLE_BITS, 6, log2 of full-wave sine table depth.
- DIVIDER, 1000, clk cycles per carrier tick (>=1).
- START_PHASE, 0, accumulator value after reset (32-bit).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  run/stop
- freq  in  32 signed  phase increment per carrier period; negative reverses rotation
- amp  in  PWM_BITS unsigned  amplitude scale; 2^PWM_BITS-1 is full
- en  out  1  registered copy of enable
- pwm_out  out  CHANNELS  PWM outputs; bit k is channel k

Behaviour:
- Reset (rst=1 at a clk edge):
  - presc=0, cnt=0, phase=START_PHASE, duty[k]=0, pwm_out=0, en=0.
  - Reset dominates every other event, including reset in mid-period.
- Prescaler:
  - presc counts 0..DIVIDER-1 on clk.
  - tick = (presc==DIVIDER-1); presc wraps to 0 on tick.
- Carrier:
  - On tick, cnt increments 0..PERIOD-1, then wraps to 0.
  - update = tick && cnt==PERIOD-1 (last tick of the period).
- Accumulator:
  - On update with enable=1: phase <= phase + freq, modulo 2^32 (two's complement wrap, no saturation).
  - With enable=0, phase holds.
- Duty computation on update:
  - Uses the pre-update phase.
  - idx_k = (phase + OFF_k)[31:32-TABLE_BITS], where OFF_k = floor(k*2^32/CHANNELS).
  - t(i) = round((2^(PWM_BITS-1)-1)*sin(2πi/2^TABLE_BITS)), signed, computed at elaboration (ROM, no runtime trig).
  - duty[k] <= 2^(PWM_BITS-1) + ((t(idx_k)*amp) >>> PWM_BITS); arithmetic shift, floor.
  - Result range is 1..2^PWM_BITS-2, so no overflow.
- Enable:
  - enable=0: duty[k] cleared to 0 on the next clk edge (immediate, not waiting for update).
  - While enable=0, pwm_out is forced 0 from the cycle after en falls.
  - After enable rises, duties load at the first following update.
- Output:
  - pwm_out[k] <= en && (cnt < duty[k]), registered, 1 clk after cnt.
  - duty 0 gives constant low.
  - duty d gives a high time of d ticks per PERIOD-tick period, starting at cnt=0.
- Simultaneous events:
  - enable falling on an update cycle: the clear wins and the phase does not advance.
  - freq/amp changes take effect only at the next update.
- All channels share cnt, so edges are start-aligned.

Test Plan (DIVIDER=1, PWM_BITS=8, TABLE_BITS=6, CHANNELS=3, START_PHASE=0):
1. Static offsets:
   - Stimulus: rst pulse, enable=1, amp=255, freq=0.
   - After first update: duty = {128,239,22} (idx 0/21/42; t=0/112/-106).
   - pwm_out[0] high for 128 of every 255 clks.
2. Forward rotation:
   - Stimulus: freq=2^26.
   - Channel 0 idx sequence 0,1,2,... one per update; wraps from 63 to 0 after 64 updates.
   - Ch0 duty at idx 16 = 254; at idx 48 = 1.
3. Reverse rotation:
   - Stimulus: freq=-2^26 from phase 0.
   - Channel 0 idx 0 then 63, 62...; duty at idx 63 = 116.
4. Amplitude:
   - amp=0: every duty = 128 regardless of phase.
   - amp changed mid-period: old duty persists until cnt wraps.
5. Enable/disable:
   - Drop enable mid-period: en=0 and pwm_out=0 the following cycles; phase frozen across 10 periods.
   - Re-enable: output resumes at the next update, from the same phase.
6. Reset mid-operation:
   - Stimulus: assert rst at cnt=100 with duties loaded.
   - Next clk: pwm_out=0, en=0, cnt=0, phase=START_PHASE.
   - After release, behaviour matches test 1 exactly.
